// File: rtl/fp_align_pipe.sv
// Two-stage operand aligner for the FP adder: orders operands by magnitude, then
// right-shifts the smaller significand and produces exact guard/round/sticky bits.
module fp_align_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a_op,
    input  logic [EXP_W+MAN_W:0]   b_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   big_sign,
    output logic                   small_sign,
    output logic [EXP_W-1:0]       exp_out,
    output logic [MAN_W:0]         man_big,
    output logic [MAN_W:0]         man_small,
    output logic                   guard,
    output logic                   round,
    output logic                   sticky,
    output logic                   swapped,
    output logic                   special,
    output logic                   nan_out,
    output logic                   eff_sub
);

    localparam int unsigned SIG_W = MAN_W + 1;
    localparam int unsigned EXT_W = SIG_W + 2;
    localparam int unsigned CMP_W = (EXP_W > 32) ? EXP_W : 32;

    // Field decode of both operands
    logic             aSign, bSign;
    logic [EXP_W-1:0] aExpF, bExpF;
    logic [MAN_W-1:0] aMan, bMan;
    logic             aExpZero, bExpZero, aExpMax, bExpMax;
    logic [EXP_W-1:0] aEffExp, bEffExp;
    logic [SIG_W-1:0] aSig, bSig;
    logic             aNan, bNan, aInf, bInf;
    logic             bGtA;

    assign {aSign, aExpF, aMan} = a_op;
    assign {bSign, bExpF, bMan} = b_op;

    assign aExpZero = (aExpF == '0);
    assign bExpZero = (bExpF == '0);
    assign aExpMax  = &aExpF;
    assign bExpMax  = &bExpF;

    // Subnormals and zero use effective exponent 1 with a clear hidden bit
    assign aEffExp = aExpZero ? EXP_W'(1) : aExpF;
    assign bEffExp = bExpZero ? EXP_W'(1) : bExpF;
    assign aSig    = {~aExpZero, aMan};
    assign bSig    = {~bExpZero, bMan};

    assign aNan = aExpMax & (|aMan);
    assign bNan = bExpMax & (|bMan);
    assign aInf = aExpMax & ~(|aMan);
    assign bInf = bExpMax & ~(|bMan);

    // Ties keep A as the big operand
    assign bGtA = {bEffExp, bSig} > {aEffExp, aSig};

    // Handshake: a stage advances when the one after it is empty or draining
    logic s1Valid;
    logic s2Ready;

    assign s2Ready  = ~out_valid | out_ready;
    assign in_ready = ~s1Valid | s2Ready;

    // Stage 1 registers
    logic             s1BigSign, s1SmallSign;
    logic [EXP_W-1:0] s1BigExp, s1Diff;
    logic [SIG_W-1:0] s1BigSig, s1SmallSig;
    logic             s1Swapped, s1Special, s1Nan, s1EffSub;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1Valid     <= 1'b0;
            s1BigSign   <= 1'b0;
            s1SmallSign <= 1'b0;
            s1BigExp    <= '0;
            s1Diff      <= '0;
            s1BigSig    <= '0;
            s1SmallSig  <= '0;
            s1Swapped   <= 1'b0;
            s1Special   <= 1'b0;
            s1Nan       <= 1'b0;
            s1EffSub    <= 1'b0;
        end else if (in_valid && in_ready) begin
            s1Valid   <= 1'b1;
            s1Swapped <= bGtA;
            s1Special <= aExpMax | bExpMax;
            s1Nan     <= aNan | bNan | (aInf & bInf & (aSign ^ bSign));
            s1EffSub  <= aSign ^ bSign;
            if (bGtA) begin
                s1BigSign   <= bSign;
                s1SmallSign <= aSign;
                s1BigExp    <= bEffExp;
                s1Diff      <= bEffExp - aEffExp;
                s1BigSig    <= bSig;
                s1SmallSig  <= aSig;
            end else begin
                s1BigSign   <= aSign;
                s1SmallSign <= bSign;
                s1BigExp    <= aEffExp;
                s1Diff      <= aEffExp - bEffExp;
                s1BigSig    <= aSig;
                s1SmallSig  <= bSig;
            end
        end else if (s2Ready) begin
            s1Valid <= 1'b0;
        end
    end

    // Alignment shift with exact sticky over every bit below round
    logic [EXT_W-1:0] extSig, shiftedC, lowMaskC;
    logic             stickyC;

    always_comb begin
        extSig   = {s1SmallSig, 2'b00};
        shiftedC = '0;
        lowMaskC = '0;
        stickyC  = |s1SmallSig;
        if (CMP_W'(s1Diff) < CMP_W'(EXT_W)) begin
            shiftedC = extSig >> s1Diff;
            lowMaskC = ~({EXT_W{1'b1}} << s1Diff);
            stickyC  = |(extSig & lowMaskC);
        end
    end

    // Stage 2 registers drive the outputs directly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            big_sign   <= 1'b0;
            small_sign <= 1'b0;
            exp_out    <= '0;
            man_big    <= '0;
            man_small  <= '0;
            guard      <= 1'b0;
            round      <= 1'b0;
            sticky     <= 1'b0;
            swapped    <= 1'b0;
            special    <= 1'b0;
            nan_out    <= 1'b0;
            eff_sub    <= 1'b0;
        end else if (s2Ready) begin
            out_valid <= s1Valid;
            if (s1Valid) begin
                big_sign   <= s1BigSign;
                small_sign <= s1SmallSign;
                exp_out    <= s1BigExp;
                man_big    <= s1BigSig;
                man_small  <= shiftedC[EXT_W-1:2];
                guard      <= shiftedC[1];
                round      <= shiftedC[0];
                sticky     <= stickyC;
                swapped    <= s1Swapped;
                special    <= s1Special;
                nan_out    <= s1Nan;
                eff_sub    <= s1EffSub;
            end
        end
    end

endmodule

// File: tb/tb_fp_align_pipe.sv
// Directed bench for fp_align_pipe: single- and double-precision alignment,
// specials, back-pressure and mid-flight reset.
module tb_fp_align_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        inValid, inReady, outValid, outReady;
    logic [31:0] aOp, bOp;
    logic        bigSign, smallSign, guardB, roundB, stickyB;
    logic        swapped, special, nanOut, effSub;
    logic [7:0]  expOut;
    logic [23:0] manBig, manSmall;

    logic        dInValid, dInReady, dOutValid, dOutReady;
    logic [63:0] dAOp, dBOp;
    logic        dBigSign, dSmallSign, dGuard, dRound, dSticky;
    logic        dSwapped, dSpecial, dNanOut, dEffSub;
    logic [10:0] dExpOut;
    logic [52:0] dManBig, dManSmall;

    fp_align_pipe dut (
        .clk(clk), .reset(reset),
        .in_valid(inValid), .in_ready(inReady), .a_op(aOp), .b_op(bOp),
        .out_valid(outValid), .out_ready(outReady),
        .big_sign(bigSign), .small_sign(smallSign), .exp_out(expOut),
        .man_big(manBig), .man_small(manSmall),
        .guard(guardB), .round(roundB), .sticky(stickyB),
        .swapped(swapped), .special(special), .nan_out(nanOut), .eff_sub(effSub)
    );

    fp_align_pipe #(.EXP_W(11), .MAN_W(52)) dutD (
        .clk(clk), .reset(reset),
        .in_valid(dInValid), .in_ready(dInReady), .a_op(dAOp), .b_op(dBOp),
        .out_valid(dOutValid), .out_ready(dOutReady),
        .big_sign(dBigSign), .small_sign(dSmallSign), .exp_out(dExpOut),
        .man_big(dManBig), .man_small(dManSmall),
        .guard(dGuard), .round(dRound), .sticky(dSticky),
        .swapped(dSwapped), .special(dSpecial), .nan_out(dNanOut), .eff_sub(dEffSub)
    );

    int nChecks = 0;
    int nPass   = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] want);
        nChecks++;
        if (got === want) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    // Issue one pair, then land on the negedge after the second register stage
    task automatic run1(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        aOp = a; bOp = b; inValid = 1'b1; outReady = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        checkVal("lat1", 64'(outValid), 64'd0);
        @(negedge clk);
        checkVal("lat2", 64'(outValid), 64'd1);
    endtask

    logic [31:0] bpB   [4] = '{32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h3D800000};
    logic [23:0] bpExp [4] = '{24'h400000, 24'h200000, 24'h100000, 24'h080000};

    initial begin
        int  sent, got, stallCnt;
        bit  stallDone, sawFull, extra;

        reset = 1'b1; inValid = 1'b0; outReady = 1'b1; aOp = '0; bOp = '0;
        dInValid = 1'b0; dOutReady = 1'b1; dAOp = '0; dBOp = '0;
        #12;
        checkVal("rstOv", 64'(outValid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkVal("rstIr", 64'(inReady), 64'd1);
        checkVal("rstMan", 64'(manBig), 64'd0);
        checkVal("rstExp", 64'(expOut), 64'd0);

        // 1.0 + 0.5
        run1(32'h3F800000, 32'h3F000000);
        checkVal("basicBig", 64'(manBig), 64'h800000);
        checkVal("basicSmall", 64'(manSmall), 64'h400000);
        checkVal("basicExp", 64'(expOut), 64'h7F);
        checkVal("basicGrs", 64'({guardB, roundB, stickyB}), 64'd0);
        checkVal("basicSwap", 64'(swapped), 64'd0);

        // diff 24: hidden bit lands in guard
        run1(32'h3F800000, 32'h33800000);
        checkVal("d24Small", 64'(manSmall), 64'd0);
        checkVal("d24Grs", 64'({guardB, roundB, stickyB}), 64'b100);

        // diff 27: beyond the extended width, everything folds into sticky
        run1(32'h3F800000, 32'h32000001);
        checkVal("d27Small", 64'(manSmall), 64'd0);
        checkVal("d27Grs", 64'({guardB, roundB, stickyB}), 64'b001);

        // equal exponents, B larger
        run1(32'h40000000, 32'h40400000);
        checkVal("eqSwap", 64'(swapped), 64'd1);
        checkVal("eqBig", 64'(manBig), 64'hC00000);
        checkVal("eqSmall", 64'(manSmall), 64'h800000);

        // exact tie keeps A big
        run1(32'h40400000, 32'h40400000);
        checkVal("tieSwap", 64'(swapped), 64'd0);

        // two subnormals
        run1(32'h00000003, 32'h00000001);
        checkVal("subExp", 64'(expOut), 64'd1);
        checkVal("subBig", 64'(manBig), 64'd3);
        checkVal("subSmall", 64'(manSmall), 64'd1);

        // -1.0 vs 2.0: signs follow magnitude ordering
        run1(32'hBF800000, 32'h40000000);
        checkVal("sgnSwap", 64'(swapped), 64'd1);
        checkVal("sgnBig", 64'({bigSign, smallSign}), 64'b01);
        checkVal("sgnSub", 64'(effSub), 64'd1);
        checkVal("sgnSmall", 64'(manSmall), 64'h400000);

        // specials
        run1(32'h7F800000, 32'hFF800000);
        checkVal("infInfSp", 64'(special), 64'd1);
        checkVal("infInfNan", 64'(nanOut), 64'd1);
        run1(32'h7FC00000, 32'h3F800000);
        checkVal("nanNan", 64'(nanOut), 64'd1);
        run1(32'h7F800000, 32'h3F800000);
        checkVal("infSp", 64'(special), 64'd1);
        checkVal("infNan", 64'(nanOut), 64'd0);
        run1(32'h7F800000, 32'h7F800000);
        checkVal("infSameNan", 64'(nanOut), 64'd0);

        // back-pressure: stall the first result for 3 cycles while streaming 4 pairs
        @(negedge clk);
        inValid = 1'b0;
        sent = 0; got = 0; stallCnt = 0; stallDone = 1'b0; sawFull = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            @(negedge clk);
            if (outValid && !stallDone) begin
                stallDone = 1'b1;
                stallCnt  = 3;
            end
            outReady = (stallCnt == 0);
            #1;
            if (stallCnt > 0) begin
                checkVal("bpHoldValid", 64'(outValid), 64'd1);
                checkVal("bpHoldData", 64'(manSmall), 64'(bpExp[0]));
                if (!inReady) sawFull = 1'b1;
                stallCnt--;
            end
            if (outValid && outReady) begin
                if (got < 4) checkVal($sformatf("bpOrder%0d", got), 64'(manSmall), 64'(bpExp[got]));
                got++;
            end
            if (sent < 4) begin
                aOp = 32'h3F800000; bOp = bpB[sent]; inValid = 1'b1;
                if (inReady) sent++;
            end else begin
                inValid = 1'b0;
            end
        end
        inValid = 1'b0;
        checkVal("bpCount", 64'(got), 64'd4);
        checkVal("bpFull", 64'(sawFull), 64'd1);
        extra = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (outValid) extra = 1'b1;
        end
        checkVal("bpNoDup", 64'(extra), 64'd0);

        // reset with two pairs in flight
        outReady = 1'b1;
        @(negedge clk);
        aOp = 32'h3F800000; bOp = 32'h3F000000; inValid = 1'b1;
        @(negedge clk);
        aOp = 32'h40000000; bOp = 32'h3F800000;
        @(posedge clk);
        #2;
        inValid = 1'b0;
        checkVal("rfPre", 64'(outValid), 64'd1);
        reset = 1'b1;
        #1;
        checkVal("rfOv", 64'(outValid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkVal("rfIr", 64'(inReady), 64'd1);
        checkVal("rfMan", 64'(manSmall), 64'd0);
        extra = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (outValid) extra = 1'b1;
        end
        checkVal("rfStale", 64'(extra), 64'd0);

        // double precision: 1.0 + 2^-54 puts the hidden bit in round
        @(negedge clk);
        dAOp = 64'h3FF0000000000000; dBOp = 64'h3C90000000000000; dInValid = 1'b1;
        @(negedge clk);
        dInValid = 1'b0;
        @(negedge clk);
        checkVal("dpValid", 64'(dOutValid), 64'd1);
        checkVal("dpGrs", 64'({dGuard, dRound, dSticky}), 64'b010);
        checkVal("dpSmall", 64'(dManSmall), 64'd0);
        checkVal("dpBig", 64'(dManBig), 64'h10000000000000);
        checkVal("dpExp", 64'(dExpOut), 64'h3FF);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
